// File: rtl/z80_pkg.sv
// z80_pkg: shared Z80 bus types, slave FSM states and bus constants.
package z80_pkg;
    typedef struct packed {
        logic [7:0]  dmaster;
        logic [15:0] addr;
        logic        inta;
    } Z80MasterBus;
    typedef struct packed {
        logic [7:0] dslave;
        logic       mwait;
    } Z80SlaveBus;
    typedef enum logic [1:0] {IDLE, WAIT, HOLD} slave_state_t;
    localparam logic [7:0] Z80_OPEN_BUS = 8'hFF;
endpackage

// File: rtl/z80_addr_decode.sv
// z80_addr_decode: aligned address-window hit detect plus offset within the window.
module z80_addr_decode #(
    parameter logic [15:0] BASE_ADDR = 16'h8000,
    parameter int          WIN_BITS  = 8
) (
    input  logic [15:0]         addr,
    output logic                hit,
    output logic [WIN_BITS-1:0] offset
);
    localparam logic [15:0] MASK = 16'((17'd1 << WIN_BITS) - 17'd1);
    assign hit    = (addr & ~MASK) == BASE_ADDR;
    assign offset = addr[WIN_BITS-1:0];
endmodule

// File: rtl/z80_slave_port.sv
// z80_slave_port: Z80 bus slave bridging CPU strobes to a req/ack back-end,
// holding mwait low until ack plus minimum waits, or until timeout.
module z80_slave_port
    import z80_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h8000,
    parameter int          WIN_BITS  = 8,
    parameter int          MIN_WAITS = 1,
    parameter int          TIMEOUT   = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  Z80MasterBus         master_in,
    input  logic                rd,
    input  logic                wr,
    input  logic [7:0]          vector,
    output Z80SlaveBus          slave_out,
    output logic                sel,
    output logic                be_req,
    output logic                be_we,
    output logic [WIN_BITS-1:0] be_addr,
    output logic [7:0]          be_wdata,
    input  logic                be_ack,
    input  logic [7:0]          be_rdata,
    output logic                timeout_err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    slave_state_t        state;
    logic                hit;
    logic                ack_seen;
    logic                done;
    logic [WIN_BITS-1:0] offset;
    logic [CW-1:0]       wait_cnt;
    logic [CW:0]         cnt_inc;

    z80_addr_decode #(.BASE_ADDR(BASE_ADDR), .WIN_BITS(WIN_BITS)) u_dec (
        .addr(master_in.addr),
        .hit(hit),
        .offset(offset)
    );

    assign sel     = hit | master_in.inta;
    assign cnt_inc = {1'b0, wait_cnt} + (CW+1)'(1);
    assign done    = (ack_seen | be_ack) & (cnt_inc >= (CW+1)'(MIN_WAITS));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            be_req           <= 1'b0;
            be_we            <= 1'b0;
            be_addr          <= '0;
            be_wdata         <= 8'h00;
            slave_out.dslave <= 8'h00;
            slave_out.mwait  <= 1'b1;
            timeout_err      <= 1'b0;
            wait_cnt         <= '0;
            ack_seen         <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (master_in.inta) begin
                        slave_out.dslave <= vector;
                        state            <= HOLD;
                    end else if (hit & (rd | wr)) begin
                        be_addr         <= offset;
                        be_we           <= wr;
                        be_wdata        <= master_in.dmaster;
                        be_req          <= 1'b1;
                        slave_out.mwait <= 1'b0;
                        wait_cnt        <= '0;
                        ack_seen        <= 1'b0;
                        state           <= WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= &wait_cnt ? wait_cnt : wait_cnt + CW'(1);
                    if (be_ack) begin
                        be_req   <= 1'b0;
                        ack_seen <= 1'b1;
                        if (!be_we) slave_out.dslave <= be_rdata;
                    end
                    // A dropped strobe abandons the access without touching dslave.
                    if (!(rd | wr)) begin
                        be_req          <= 1'b0;
                        slave_out.mwait <= 1'b1;
                        state           <= IDLE;
                    end else if (done) begin
                        slave_out.mwait <= 1'b1;
                        state           <= HOLD;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        be_req           <= 1'b0;
                        slave_out.dslave <= Z80_OPEN_BUS;
                        slave_out.mwait  <= 1'b1;
                        timeout_err      <= 1'b1;
                        state            <= HOLD;
                    end
                end
                default: if (!(rd | wr | master_in.inta)) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_z80_slave_port.sv
// tb_z80_slave_port: directed checks of the Z80 slave port with MIN_WAITS=1 and MIN_WAITS=4 instances.
module tb_z80_slave_port;
    import z80_pkg::*;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    Z80MasterBus master_in = '0;
    logic        rd = 1'b0, wr = 1'b0, be_ack = 1'b0;
    logic [7:0]  vector = 8'h00, be_rdata = 8'h00;
    Z80SlaveBus  so1, so4;
    logic        sel1, req1, we1, to1, sel4, req4, we4, to4;
    logic [7:0]  addr1, wdata1, addr4, wdata4;
    int          cnt1 = 0, cnt4 = 0, n_cmp = 0, n_err = 0;
    int          c1, c4, tcount;

    always #5 clk = ~clk;

    z80_slave_port #(.MIN_WAITS(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .master_in(master_in), .rd(rd), .wr(wr),
        .vector(vector), .slave_out(so1), .sel(sel1), .be_req(req1), .be_we(we1),
        .be_addr(addr1), .be_wdata(wdata1), .be_ack(be_ack), .be_rdata(be_rdata),
        .timeout_err(to1)
    );

    z80_slave_port #(.MIN_WAITS(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .master_in(master_in), .rd(rd), .wr(wr),
        .vector(vector), .slave_out(so4), .sel(sel4), .be_req(req4), .be_we(we4),
        .be_addr(addr4), .be_wdata(wdata4), .be_ack(be_ack), .be_rdata(be_rdata),
        .timeout_err(to4)
    );

    // Running totals of clock edges that saw mwait low, one per instance.
    always @(posedge clk) begin
        cnt1 <= cnt1 + int'(!so1.mwait);
        cnt4 <= cnt4 + int'(!so4.mwait);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Starts an access on the next negedge and pulses be_ack in WAIT cycle ack_at; strobe stays high.
    task automatic access(input logic [15:0] a, input logic w, input logic [7:0] d,
                          input int ack_at, input logic [7:0] rdata);
        @(negedge clk);
        master_in.addr    = a;
        master_in.dmaster = d;
        rd = !w;
        wr = w;
        for (int i = 1; i <= ack_at; i++) begin
            @(negedge clk);
            if (i == ack_at) begin
                be_ack   = 1'b1;
                be_rdata = rdata;
            end
        end
        @(negedge clk);
        be_ack = 1'b0;
    endtask

    task automatic release_bus();
        rd = 1'b0;
        wr = 1'b0;
        master_in.inta = 1'b0;
        cyc(2);
    endtask

    initial begin
        cyc(2);
        check("rst_req", req1, 0);
        check("rst_mwait", so1.mwait, 1);
        check("rst_dslave", so1.dslave, 8'h00);
        check("rst_addr", addr1, 8'h00);
        check("rst_to", to1, 0);
        reset_n = 1'b1;
        cyc(1);

        c1 = cnt1;
        access(16'h8012, 1'b0, 8'h00, 3, 8'hA5);
        check("rd_addr", addr1, 8'h12);
        check("rd_we", we1, 0);
        check("rd_req_drop", req1, 0);
        check("rd_low3", cnt1 - c1, 3);
        check("rd_mwait", so1.mwait, 1);
        check("rd_data", so1.dslave, 8'hA5);
        cyc(1);
        check("rd_data_hold", so1.dslave, 8'hA5);
        release_bus();

        c1 = cnt1;
        c4 = cnt4;
        access(16'h80FF, 1'b1, 8'h3C, 1, 8'h99);
        check("wr_we", we4, 1);
        check("wr_wdata", wdata4, 8'h3C);
        check("wr_addr", addr4, 8'hFF);
        check("wr_req_drop", req4, 0);
        cyc(4);
        check("wr_low4", cnt4 - c4, 4);
        check("wr_low1_min1", cnt1 - c1, 1);
        check("wr_dslave4", so4.dslave, 8'hA5);
        check("wr_dslave1", so1.dslave, 8'hA5);
        release_bus();

        c1 = cnt1;
        tcount = 0;
        master_in.addr = 16'h8001;
        rd = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            tcount += int'(to1);
        end
        check("to_low64", cnt1 - c1, 64);
        check("to_pulse", tcount, 1);
        check("to_dslave", so1.dslave, 8'hFF);
        check("to_req", req1, 0);
        be_ack   = 1'b1;
        be_rdata = 8'h11;
        @(negedge clk);
        be_ack = 1'b0;
        cyc(1);
        check("late_ack_dslave", so1.dslave, 8'hFF);
        check("late_ack_mwait", so1.mwait, 1);
        release_bus();

        c1 = cnt1;
        master_in.addr = 16'h0000;
        master_in.inta = 1'b1;
        vector         = 8'h7E;
        #1;
        check("inta_sel", sel1, 1);
        @(negedge clk);
        check("inta_vec", so1.dslave, 8'h7E);
        check("inta_mwait", so1.mwait, 1);
        cyc(2);
        check("inta_req", req1, 0);
        check("inta_nolow", cnt1 - c1, 0);
        release_bus();

        master_in.addr = 16'h8020;
        rd = 1'b1;
        cyc(2);
        check("mid_req", req1, 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_req", req1, 0);
        check("arst_mwait", so1.mwait, 1);
        check("arst_dslave", so1.dslave, 8'h00);
        rd     = 1'b0;
        be_ack = 1'b1;
        @(negedge clk);
        be_ack  = 1'b0;
        reset_n = 1'b1;
        cyc(1);
        access(16'h8033, 1'b0, 8'h00, 1, 8'h5A);
        check("post_rst_addr", addr1, 8'h33);
        check("post_rst_data", so1.dslave, 8'h5A);
        release_bus();

        c1 = cnt1;
        master_in.addr = 16'h9000;
        rd = 1'b1;
        #1;
        check("miss_sel", sel1, 0);
        cyc(3);
        check("miss_req", req1, 0);
        check("miss_mwait", so1.mwait, 1);
        check("miss_nolow", cnt1 - c1, 0);
        release_bus();

        access(16'h8001, 1'b0, 8'h00, 1, 8'hC1);
        check("b2b_first", so1.dslave, 8'hC1);
        master_in.addr = 16'h8002;
        cyc(3);
        check("b2b_no_restart", req1, 0);
        check("b2b_held", so1.dslave, 8'hC1);
        rd = 1'b0;
        access(16'h8002, 1'b0, 8'h00, 1, 8'hC2);
        check("b2b_second_addr", addr1, 8'h02);
        check("b2b_second", so1.dslave, 8'hC2);
        release_bus();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/z80_slave_port.md
Name: z80_slave_port

Overview:
- Slave-side responder for the Z80 bus. It produces one Z80SlaveBus entry that feeds the system slave multiplexer.
- It decodes an address window and converts Z80 read/write/interrupt-acknowledge strobes into a req/ack handshake to a back-end (register file, RAM, peripheral).
- It holds the CPU in wait (mwait low) until the back-end answers, the minimum wait count expires, or a timeout fires.

Parameters:
- BASE_ADDR, 16'h8000, base of the decoded window; must be aligned to 2**WIN_BITS.
- WIN_BITS, 8, window size is 2**WIN_BITS bytes; legal range 1..16.
- MIN_WAITS, 1, minimum number of cycles mwait stays low per access; legal range 0..15.
- TIMEOUT, 64, cycles without ack before the access is aborted; must exceed MIN_WAITS.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- master_in  in  Z80MasterBus  dmaster[7:0], addr[15:0], inta from the CPU.
- rd  in  1  active-high read strobe (memory/IO decode done upstream).
- wr  in  1  active-high write strobe.
- vector  in  8  IM2 vector returned on interrupt acknowledge.
- slave_out  out  Z80SlaveBus  dslave[7:0], mwait (active-low wait; 1 = ready).
- sel  out  1  combinational window hit: (addr & ~mask) == BASE_ADDR, or inta.
- be_req  out  1  back-end request, level held until ack or abort.
- be_we  out  1  1 = write.
- be_addr  out  WIN_BITS  offset within the window.
- be_wdata  out  8  write data.
- be_ack  in  1  back-end completion, single-cycle pulse.
- be_rdata  in  8  read data, valid when be_ack is high.
- timeout_err  out  1  one-cycle pulse when an access is aborted.

Behaviour:
- Reset (asynchronous, reset_n low): state IDLE; be_req=0; be_we=0; be_addr=0; be_wdata=0; slave_out.dslave=8'h00; slave_out.mwait=1; timeout_err=0; counters=0. Reset during an access drops be_req immediately; a late be_ack is ignored.
- Start condition: "start" = sel & (rd|wr|inta) while in IDLE; it is edge-qualified by the FSM, not by the strobe itself.
- IDLE -> inta: go to HOLD the same cycle. dslave=vector, mwait=1, no back-end request.
- IDLE -> rd or wr hit:
  - latch be_addr=addr[WIN_BITS-1:0], be_we=wr, be_wdata=dmaster.
  - be_req=1, mwait=0, wait_cnt=0.
  - go to WAIT.
  - rd and wr both high: treat as a write.
- WAIT:
  - wait_cnt increments every cycle and saturates; mwait=0.
  - On be_ack: drop be_req; for reads, capture be_rdata into dslave; set ack_seen.
  - Leave WAIT to HOLD when ack_seen (or ack this cycle) and wait_cnt+1 >= MIN_WAITS.
  - With MIN_WAITS=0 and ack on the first WAIT cycle, mwait is low for exactly 1 cycle.
  - If wait_cnt reaches TIMEOUT-1 with no ack: drop be_req, dslave=8'hFF, pulse timeout_err, go to HOLD.
  - If the strobe (rd|wr) drops while in WAIT (protocol violation): drop be_req, go to IDLE, mwait=1.
- HOLD: mwait=1; dslave held stable. Return to IDLE when rd, wr and inta are all low. No new access can start until the strobes have gone low.
- Writes: dslave is not updated (keeps its previous value).
- Back-end handshake: be_req asserts in the cycle after start is seen. be_ack in the same cycle as be_req's first assertion is legal. Any be_ack outside WAIT is ignored.
- Outside the window: mwait=1, dslave unchanged, the FSM stays in IDLE (the multiplexer masks this port out).

Decomposition:
- Shared package z80_pkg holds:
  - the Z80MasterBus and Z80SlaveBus typedefs (already in Z80Bus.vh; move them there);
  - the state enum slave_state_t {IDLE, WAIT, HOLD};
  - the constant Z80_OPEN_BUS = 8'hFF.
- One sub-module, z80_addr_decode (BASE_ADDR, WIN_BITS): combinational hit plus offset. It is reused by other slaves.

Test Plan:
- Read, MIN_WAITS=1, be_ack on the 3rd WAIT cycle with rdata=8'hA5 at addr 16'h8012 -> be_addr=8'h12; mwait low for exactly 3 cycles; dslave=8'hA5 from release until rd drops.
- Write dmaster=8'h3C at 16'h80FF, MIN_WAITS=4, immediate ack -> be_we=1, be_wdata=8'h3C; mwait low 4 cycles; dslave unchanged.
- No ack, TIMEOUT=64 -> mwait low 64 cycles; timeout_err high for 1 cycle; dslave=8'hFF; a late ack afterwards has no effect.
- inta with vector=8'h7E -> mwait never low; dslave=8'h7E the cycle after inta; be_req stays 0.
- reset_n low mid-WAIT -> be_req, mwait, dslave return to reset values asynchronously; after release, the next read completes normally.
- rd at 16'h9000 (miss) -> sel=0; be_req stays 0; mwait=1. Back-to-back reads separated by a single-cycle strobe gap -> both serviced, and HOLD exits only once the gap is seen.
